serial_subtractor16: RTL

SERIAL_SUBTRACTOR16 -- requirements
Module: serial_subtractor16

---
 rtl/serial_subtractor16_if.sv | 24 ++
 rtl/serial_subtractor16.sv | 110 +++++++++++
 2 files changed

// File: rtl/serial_subtractor16_if.sv
// Request/response bundle for the bit-serial subtractor.
// The master drives the operands and start; the slave returns the status and the result.
interface serial_subtractor16_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] f;
  logic             ovf;
  logic             borrow;

  modport master (
    output start, a, b,
    input  busy, done, f, ovf, borrow
  );

  modport slave (
    input  start, a, b,
    output busy, done, f, ovf, borrow
  );
endinterface

// File: rtl/serial_subtractor16.sv
// Bit-serial two's-complement subtractor, LSB first, one bit per clock.
// Computes a + ~b + 1 through a single full adder whose carry flop starts at 1.
module serial_subtractor16 #(
  parameter int unsigned WIDTH = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  serial_subtractor16_if.slave bus
);
  localparam int unsigned IW = $clog2(WIDTH);
  localparam int unsigned CW = IW + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic             borrow_q, borrow_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] f_q, f_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             a_bit, nb_bit, sum_bit, carry_nxt, last_bit;

  // Next-state, datapath and registered-output values
  always_comb begin
    state_d   = state;
    done_d    = 1'b0;
    ovf_d     = ovf_q;
    borrow_d  = borrow_q;
    carry_d   = carry_q;
    f_d       = f_q;
    a_d       = a_q;
    b_d       = b_q;
    sh_d      = sh_q;
    cnt_d     = cnt_q;
    a_bit     = a_q[cnt_q[IW-1:0]];
    nb_bit    = ~b_q[cnt_q[IW-1:0]];
    sum_bit   = a_bit ^ nb_bit ^ carry_q;
    carry_nxt = (a_bit & nb_bit) | (a_bit & carry_q) | (nb_bit & carry_q);
    last_bit  = (cnt_q == CW'(WIDTH - 1));

    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = RUN;
          a_d     = bus.a;
          b_d     = bus.b;
          cnt_d   = '0;
          carry_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sh_d    = {sum_bit, sh_q[WIDTH-1:1]};
        carry_d = carry_nxt;
        cnt_d   = cnt_q + CW'(1);
        if (last_bit) begin
          state_d  = DONE;
          done_d   = 1'b1;
          f_d      = sh_d;
          borrow_d = ~carry_nxt;
          ovf_d    = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sh_d[WIDTH-1] != a_q[WIDTH-1]);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      borrow_q <= 1'b0;
      carry_q  <= 1'b1;
      f_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sh_q     <= '0;
      cnt_q    <= '0;
    end else begin
      state    <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      borrow_q <= borrow_d;
      carry_q  <= carry_d;
      f_q      <= f_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.f      = f_q;
  assign bus.ovf    = ovf_q;
  assign bus.borrow = borrow_q;
endmodule
